horner_pkt_tx: RTL
==================

Name: horner_pkt_tx

Overview:
- AXI4-Stream packet transmitter that builds the input stream the affine/matrix-vector engine consumes.
- Each packet is 3 matrix-row beats (Q16 coefficients, 4 lanes each), then N vector beats forwarded from an upstream vector stream, with tlast on the last vector beat.
- Sits between the host/DMA-side vector source and the engine's s00_axis slave port. Replaces hand-driven stimulus framing in system-level use.

Parameters:
- DATA_WIDTH, 16, bits per lane.
- LANES, 4, lanes per beat; fixed at 4 for matrix framing (3 rows x 4 coefficients).
- CNT_WIDTH, 16, width of the vector-count field.
- W_INSERT, 0, when 1, lane 3 of every forwarded vector beat is replaced by the value 1.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to send a packet; ignored unless idle.
- vec_count  in  CNT_WIDTH  number of vector beats; latched when start is accepted.
- mat_coef  in  12*DATA_WIDTH  coefficient k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=0..11, row-major 3x4; latched when start is accepted.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse after the final beat handshake.
- s_axis_tdata  in  LANES*DATA_WIDTH  upstream vector beat; lane0 in the LSBs.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- m00_axis_tdata  out  LANES*DATA_WIDTH  packet beat.
- m00_axis_tvalid  out  1  packet valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  last beat of the packet.

Behaviour:
- Reset:
  - Async assert of aresetn forces state IDLE.
  - busy, done, s_axis_tready, m00_axis_tvalid, m00_axis_tlast and m00_axis_tdata all go to 0.
  - A reset mid-packet abandons the packet. No tlast is emitted.
- Start handling:
  - start is accepted only in IDLE with vec_count != 0.
  - start with vec_count == 0 is ignored: no beats, no done.
  - start while busy is ignored.
- States:
  - IDLE -> MAT on accepted start. Latch mat_coef and vec_count; row index := 0.
  - MAT: load row r into the output register as {coef[4r+3], coef[4r+2], coef[4r+1], coef[4r]}, tlast=0.
  - MAT advances the row on each output handshake (tvalid & tready). After the row-2 handshake -> VEC.
  - VEC: forward upstream beats; remaining count decrements per accepted upstream beat.
  - VEC -> DONE on the handshake of the beat carrying tlast.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
  - start asserted during DONE is ignored.
- Output register:
  - Single registered output stage. m00_axis_tvalid/tdata/tlast are held stable while tvalid=1 and tready=0 (AXIS rule).
  - The register loads when empty or when the current beat handshakes in the same cycle, giving 1 beat/cycle with tready=1.
- Upstream handshake:
  - s_axis_tready = (state==VEC) && remaining != 0 && (!m00_axis_tvalid || m00_axis_tready).
  - s_axis_tready is 0 in IDLE/MAT/DONE; excess upstream beats are stalled, not dropped.
- tlast: set on the forwarded beat accepted while remaining == 1.
- W_INSERT=1: bits [4*DATA_WIDTH-1:3*DATA_WIDTH] of forwarded vector beats are set to 1. Matrix beats are unaffected.
- Latency:
  - start sampled at edge T -> row-0 beat valid after edge T+1.
  - With tready=1: rows at T+1, T+2, T+3.
  - An upstream beat accepted at edge E appears on m00 after edge E (valid from E+1 cycle).
- busy: 1 from the cycle after start acceptance through the final tlast handshake cycle.
- Arithmetic: none. Data passes bit-exact (two's complement preserved). The count is unsigned, with no wrap (stops at 0).

Test Plan:
- Basic packet:
  - Stimulus: coefs {41,0,0,-20480, 0,41,0,-16384, 0,0,41,-17613}, vec_count=2, tready=1, upstream vectors (300,800,500,1) and (600,0,400,1).
  - Required response: beats 0xB000_0000_0000_0029, 0xC000_0000_0029_0000, 0xBB33_0029_0000_0000, 0x0001_01F4_0320_012C, 0x0001_0190_0000_0258; tlast only on the 5th beat; done one cycle later.
- Backpressure:
  - Stimulus: same packet, m00_axis_tready toggling 1,0,0,1 repeatedly.
  - Required response: identical beat sequence; tdata/tlast stable during stalls; no beat duplicated or lost.
- Upstream starvation and excess:
  - Stimulus: vec_count=5; s_axis_tvalid gapped; 11 vectors offered.
  - Required response: exactly 5 vectors forwarded, tlast on the 5th; s_axis_tready=0 afterwards with the 6th vector held upstream.
- Ignored starts:
  - Stimulus: start with vec_count=0; start pulsed mid-packet.
  - Required response: no output beats and no done for the first; the in-flight packet is unaffected by the second.
- W_INSERT=1:
  - Stimulus: upstream vector (25,25,75,0xFFFF).
  - Required response: output beat 0x0001_004B_0019_0019.
- Reset mid-packet:
  - Stimulus: aresetn low during the 2nd matrix beat.
  - Required response: all outputs 0 immediately. A new start after release sends a complete packet starting with row 0.

Source files
------------

// File: rtl/horner_pkt_tx.sv
// Frames one engine packet: three matrix-row beats from latched coefficients,
// then vec_count forwarded upstream vector beats with tlast on the final one.
//
// state | meaning
// IDLE  | waiting for start with a non-zero vector count
// MAT   | emitting matrix rows 0..2 from the latched coefficients
// VEC   | forwarding upstream beats until the counted last beat handshakes
// DONE  | one-cycle done pulse, then back to IDLE
module horner_pkt_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int CNT_WIDTH  = 16,
   parameter int W_INSERT   = 0
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        start,
   input  logic [CNT_WIDTH-1:0]        vec_count,
   input  logic [12*DATA_WIDTH-1:0]    mat_coef,
   output logic                        busy,
   output logic                        done,
   input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [LANES*DATA_WIDTH-1:0] m00_axis_tdata,
   output logic                        m00_axis_tvalid,
   input  logic                        m00_axis_tready,
   output logic                        m00_axis_tlast
);

   localparam int BW = LANES * DATA_WIDTH;
   localparam int CW = 12 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, MAT, VEC, DONE} state_t;

   state_t               state_q, state_d;
   logic [1:0]           row_q, row_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]        coef_q, coef_d;
   logic [BW-1:0]        tdata_q, tdata_d;
   logic                 tvalid_q, tvalid_d;
   logic                 tlast_q, tlast_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 out_free;
   logic                 m_hs;
   logic                 s_rdy;
   logic                 s_hs;
   logic [BW-1:0]        fwd_beat;
   logic [BW-1:0]        row_beat;

   always_comb begin
      out_free = !tvalid_q || m00_axis_tready;
      m_hs     = tvalid_q && m00_axis_tready;
      s_rdy    = (state_q == VEC) && (rem_q != '0) && out_free;
      s_hs     = s_axis_tvalid && s_rdy;

      // Lane 3 carries the homogeneous w term when insertion is enabled.
      fwd_beat = s_axis_tdata;
      if (W_INSERT != 0) begin
         fwd_beat[4*DATA_WIDTH-1:3*DATA_WIDTH] = DATA_WIDTH'(1);
      end

      case (row_q)
         2'd1:    row_beat = coef_q[BW +: BW];
         2'd2:    row_beat = coef_q[2*BW +: BW];
         default: row_beat = coef_q[0 +: BW];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      rem_d    = rem_q;
      coef_d   = coef_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (vec_count != '0)) begin
               coef_d   = mat_coef;
               rem_d    = vec_count;
               tdata_d  = mat_coef[0 +: BW];
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               row_d    = 2'd1;
               busy_d   = 1'b1;
               state_d  = MAT;
            end
         end
         MAT: begin
            // row_q is the next row to load; 3 means row 2 is the beat on the bus.
            if (row_q != 2'd3) begin
               if (out_free) begin
                  tdata_d  = row_beat;
                  tvalid_d = 1'b1;
                  row_d    = row_q + 2'd1;
               end
            end else if (m_hs) begin
               tvalid_d = 1'b0;
               state_d  = VEC;
            end
         end
         VEC: begin
            if (s_hs) begin
               tdata_d  = fwd_beat;
               tvalid_d = 1'b1;
               tlast_d  = (rem_q == CNT_WIDTH'(1));
               rem_d    = rem_q - CNT_WIDTH'(1);
            end else if (m_hs) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               if (tlast_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         row_q    <= '0;
         rem_q    <= '0;
         coef_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         rem_q    <= rem_d;
         coef_q   <= coef_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign s_axis_tready   = s_rdy;
   assign m00_axis_tdata  = tdata_q;
   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tlast  = tlast_q;

endmodule
